// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter for N ports sharing a line memory, one operation at a time with fixed latency
module mem_arbiter #(
  parameter int N_PORTS = 2,
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int MEM_SIZE = 4096,
  parameter int MEM_LATENCY = 5,
  parameter string MEM_FILE = ""
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             req_valid,
  input  logic [N_PORTS-1:0]             req_we,
  input  logic [N_PORTS*WORD_SIZE-1:0]   req_addr,
  input  logic [N_PORTS*LINE_SIZE-1:0]   req_wdata,
  output logic [N_PORTS-1:0]             req_ready,
  output logic [N_PORTS-1:0]             res_valid,
  output logic [WORD_SIZE-1:0]           res_addr,
  output logic [LINE_SIZE-1:0]           res_data,
  output logic                           busy
);
  localparam int OFF = $clog2(LINE_SIZE / 8);
  localparam int NUM_LINES = MEM_SIZE * 8 / LINE_SIZE;
  localparam int IW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam int CW = MEM_LATENCY > 2 ? $clog2(MEM_LATENCY - 1) : 1;
  localparam logic [WORD_SIZE-1:0] MASK = ~((WORD_SIZE'(1) << OFF) - WORD_SIZE'(1));

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        rr, g, gnt;
  logic                 any, we_g, we_l;
  logic [WORD_SIZE-1:0] a_g, addr_l;
  logic [LINE_SIZE-1:0] d_g, data_l;
  logic [IW-1:0]        idx_l;
  logic [LINE_SIZE-1:0] mem [NUM_LINES];

  function automatic logic [IW-1:0] line_idx(input logic [WORD_SIZE-1:0] a);
    logic [WORD_SIZE-1:0] l;
    l = a >> OFF;
    return IW'(l % WORD_SIZE'(NUM_LINES));
  endfunction

  always_comb begin
    g = rr;
    any = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_valid[PW'((int'(rr) + i) % N_PORTS)]) begin
        g = PW'((int'(rr) + i) % N_PORTS);
        any = 1'b1;
      end
    end
    we_g = req_we[g];
    a_g = req_addr[g*WORD_SIZE +: WORD_SIZE];
    d_g = req_wdata[g*LINE_SIZE +: LINE_SIZE];
    req_ready = (rst && any && state == IDLE) ? N_PORTS'(1) << g : '0;
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (|req_ready && we_g) mem[line_idx(a_g)] <= d_g;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rr <= '0;
      gnt <= '0;
      we_l <= 1'b0;
      addr_l <= '0;
      data_l <= '0;
      idx_l <= '0;
      res_valid <= '0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_valid <= '0;
      if (state == IDLE && any) begin
        gnt <= g;
        we_l <= we_g;
        addr_l <= a_g & MASK;
        data_l <= d_g;
        idx_l <= line_idx(a_g);
        rr <= (g == PW'(N_PORTS - 1)) ? '0 : g + 1'b1;
        if (MEM_LATENCY == 1) begin
          state <= RESP;
          res_valid <= N_PORTS'(1) << g;
          res_addr <= a_g & MASK;
          res_data <= we_g ? d_g : mem[line_idx(a_g)];
        end else begin
          state <= WAIT;
          cnt <= CW'(MEM_LATENCY - 2);
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          state <= RESP;
          res_valid <= N_PORTS'(1) << gnt;
          res_addr <= addr_l;
          res_data <= we_l ? data_l : mem[idx_l];
        end
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of latency, round-robin, wrap, reset and LAT=1 / 4-port configurations
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;

  localparam logic [127:0] D = 128'h11112222333344445555666677778888;
  localparam logic [127:0] E = 128'hdeadbeef0123456789abcdeffeedface;
  localparam logic [127:0] F = 128'hcafef00d00112233445566778899aabb;

  logic [1:0] va, wea, rra, rva;
  logic [63:0] aa;
  logic [255:0] da;
  logic [31:0] raa;
  logic [127:0] rda;
  logic ba;
  mem_arbiter #(.N_PORTS(2), .MEM_LATENCY(5)) ua (
    .clk(clk), .rst(rst), .req_valid(va), .req_we(wea), .req_addr(aa), .req_wdata(da),
    .req_ready(rra), .res_valid(rva), .res_addr(raa), .res_data(rda), .busy(ba));

  logic [1:0] vb, web, rrb, rvb;
  logic [63:0] ab;
  logic [255:0] db;
  logic [31:0] rab;
  logic [127:0] rdb;
  logic bb;
  mem_arbiter #(.N_PORTS(2), .MEM_LATENCY(1)) ub (
    .clk(clk), .rst(rst), .req_valid(vb), .req_we(web), .req_addr(ab), .req_wdata(db),
    .req_ready(rrb), .res_valid(rvb), .res_addr(rab), .res_data(rdb), .busy(bb));

  logic [3:0] vc, wec, rrc, rvc;
  logic [127:0] ac;
  logic [511:0] dc;
  logic [31:0] rac;
  logic [127:0] rdc;
  logic bc;
  mem_arbiter #(.N_PORTS(4), .MEM_LATENCY(2)) uc (
    .clk(clk), .rst(rst), .req_valid(vc), .req_we(wec), .req_addr(ac), .req_wdata(dc),
    .req_ready(rrc), .res_valid(rvc), .res_addr(rac), .res_data(rdc), .busy(bc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", t, o, e);
    end
  endtask

  task automatic a_op(input string t, input logic [1:0] eg, input logic [31:0] ea,
                      input logic [127:0] ed, input bit chkd, input bit drop);
    #1;
    chk({t, "_ready"}, rra, eg);
    for (int i = 1; i < 5; i++) begin
      tick;
      if (drop && i == 1) begin
        va = '0;
        wea = '0;
      end
      chk({t, "_wait"}, {rva, rra, ba}, 5'b00001);
    end
    tick;
    chk({t, "_valid"}, rva, eg);
    chk({t, "_addr"}, raa, ea);
    if (chkd) chk({t, "_data"}, rda, ed);
    tick;
  endtask

  logic [3:0] ge [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};

  initial begin
    va = '1; wea = '0; aa = '0; da = '0;
    vb = '0; web = '0; ab = '0; db = '0;
    vc = '0; wec = '0; ac = '0; dc = '0;
    tick;
    chk("reset_ctl", {rra, rva, ba}, 5'b0);
    chk("reset_addr", raa, 32'h0);
    chk("reset_data", rda, 128'h0);
    va = '0;
    @(negedge clk) rst = 1'b1;
    tick;
    aa[63:32] = 32'h40; da[255:128] = D; wea = 2'b10; va = 2'b10;
    a_op("wr1", 2'b10, 32'h40, D, 1'b1, 1'b1);
    chk("idle_after_resp", {rva, ba}, 3'b000);
    chk("data_hold", rda, D);
    aa[63:32] = 32'h4C; va = 2'b10;
    a_op("rd1", 2'b10, 32'h40, D, 1'b1, 1'b1);
    aa[31:0] = 32'h1040; va = 2'b01;
    a_op("wrap", 2'b01, 32'h1040, D, 1'b1, 1'b1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick;
    aa = {32'h80, 32'h40}; wea = '0; va = 2'b11;
    for (int k = 0; k < 4; k++)
      a_op(k % 2 ? "rr_p1" : "rr_p0", k % 2 ? 2'b10 : 2'b01, k % 2 ? 32'h80 : 32'h40, D, k % 2 == 0, 1'b0);
    va = '0;
    aa[31:0] = 32'h100; da[127:0] = E; wea = 2'b01; va = 2'b01;
    #1;
    chk("rstw_ready", rra, 2'b01);
    tick;
    va = '0; wea = '0;
    tick;
    rst = 1'b0;
    #1;
    chk("rstw_ctl", {rra, rva, ba}, 5'b0);
    chk("rstw_addr", raa, 32'h0);
    chk("rstw_data", rda, 128'h0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("rstw_novalid", {rva, ba}, 3'b0);
    end
    aa = {32'h40, 32'h100}; va = 2'b11;
    a_op("rstw_rd", 2'b01, 32'h100, E, 1'b1, 1'b1);
    ab[31:0] = 32'h20; db[127:0] = F; web = 2'b01; vb = 2'b01;
    #1;
    chk("l1_wr_ready", {rrb, bb}, 3'b010);
    tick;
    web = '0; ab[31:0] = 32'h2C;
    chk("l1_wr_resp", {rvb, rrb, bb}, 5'b01001);
    chk("l1_wr_data", rdb, F);
    tick;
    chk("l1_idle", {rvb, rrb, bb}, 5'b00010);
    tick;
    chk("l1_rd_resp", {rvb, rrb, bb}, 5'b01001);
    chk("l1_rd_addr", rab, 32'h20);
    chk("l1_rd_data", rdb, F);
    vb = '0;
    tick;
    chk("l1_done", {rvb, bb}, 3'b000);
    vc = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) vc = 4'b1110;
      #1;
      chk("p4_grant", rrc, ge[k]);
      tick;
      if (k == 3) vc = 4'b1010;
      chk("p4_wait", {rvc, rrc}, 8'h0);
      tick;
      chk("p4_valid", rvc, ge[k]);
      tick;
    end
    vc = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
